canny_edge_overlay: RTL and testbench
=====================================

Name: canny_edge_overlay

Overview:
- Final stage after the edge detector: consumes the 8-bit edge map (img_out FIFO) and a raster-aligned copy of the original 24-bit RGB image (separate FIFO), both in raster order.
- Emits a 24-bit RGB frame: edge pixels are painted HIGHLIGHT_COLOR; non-edge pixels pass through, optionally dimmed.
- Tracks x/y position, masks a configurable border, and pulses frame_done after the last pixel. Feeds a 24-bit output FIFO.

Parameters:
- WIDTH, 720, pixels per line.
- HEIGHT, 540, lines per frame.
- EDGE_THRESH, 8'd128, edge byte >= this value marks an edge pixel.
- HIGHLIGHT_COLOR, 24'hFF0000, RGB written for edge pixels, packed as {R,G,B}.
- BORDER, 2, pixels at each image edge where edges are ignored (0 = no mask).
- DIM_BG, 1, 1 = non-edge pixels have each channel halved (>>1); 0 = pass through unchanged.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rgb_rd_en  out  1  pop original-image FIFO.
- rgb_empty  in  1  original-image FIFO empty.
- rgb_dout  in  24  original pixel {R,G,B}; valid while !rgb_empty (first-word fall-through).
- edge_rd_en  out  1  pop edge FIFO.
- edge_empty  in  1  edge FIFO empty.
- edge_dout  in  8  edge byte; valid while !edge_empty.
- out_wr_en  out  1  write to output FIFO.
- out_full  in  1  output FIFO full.
- out_din  out  24  overlaid pixel.
- frame_done  out  1  one-cycle pulse with the write of the last pixel of a frame.

Behaviour:
- Reset (reset=0, asynchronous): out_wr_en=0, out_din=0, frame_done=0, x=0, y=0, state=S_RUN. rgb_rd_en and edge_rd_en are combinational and read 0 while reset is asserted.
- fire = (state==S_RUN) && !rgb_empty && !edge_empty && !out_full.
- rgb_rd_en = edge_rd_en = fire. The two streams always pop together; neither is ever popped alone.
- Latency: 1 cycle. On a fire cycle, out_din and out_wr_en=1 are registered and appear on the next edge. A non-fire cycle registers out_wr_en=0; out_din holds its last value.
- is_edge = (edge_dout >= EDGE_THRESH) && (x >= BORDER) && (x < WIDTH-BORDER) && (y >= BORDER) && (y < HEIGHT-BORDER).
- out_din = HIGHLIGHT_COLOR if is_edge. Otherwise:
  - DIM_BG=1: {R>>1, G>>1, B>>1}, each channel shifted independently, no carry between channels.
  - DIM_BG=0: rgb_dout unchanged.
- Counters advance on fire only:
  - x increments; at x==WIDTH-1, x wraps to 0 and y increments.
  - At x==WIDTH-1 and y==HEIGHT-1: x=0, y=0, state goes to S_FLUSH, and frame_done=1 is registered together with the final out_wr_en.
- Counter widths: $clog2(WIDTH) and $clog2(HEIGHT).
- States:
  - S_RUN: normal operation, fire allowed.
  - S_FLUSH: exactly one cycle, fire forced to 0 (frame separator); always returns to S_RUN.
- Backpressure: out_full=1 blocks fire. Data stays in the input FIFOs and no pixel is dropped or duplicated. out_full is sampled in the same cycle as fire; the output FIFO absorbs the one in-flight registered write.
- Starvation: if either input is empty, no pop and no write. Counters hold.
- Reset mid-frame: counters and outputs clear immediately. The next popped pair is treated as pixel (0,0).
- BORDER=0 leaves the full frame eligible. The border comparison must not underflow (use unsigned compare with the width-extended constant).

Decomposition:
- Shared package canny_pkg: pixel typedefs rgb_t (packed struct r,g,b 8-bit each) and gray_t (8-bit); state enum overlay_state_t {S_RUN, S_FLUSH}; default HIGHLIGHT_COLOR constant.
- One natural sub-module: raster_counter (WIDTH/HEIGHT, advance input, x, y, last_pixel outputs). It is reusable by other stages that track position.

Test Plan:
- WIDTH=4, HEIGHT=3, BORDER=0, DIM_BG=0; edge bytes all 0, rgb = 24'h102030 -> 12 writes of 24'h102030; frame_done high only on the 12th write.
- Same setup with edge_dout=8'hFF at pixel 5 -> write 6 is 24'hFF0000, all others 24'h102030.
- DIM_BG=1, rgb=24'hFF8101, edge 0 -> out_din=24'h7F4000 (channels halved independently).
- WIDTH=6, HEIGHT=6, BORDER=2, all edges 8'hFF -> only (2,2),(3,2),(2,3),(3,3) give HIGHLIGHT_COLOR; all other pixels give dimmed rgb.
- Hold out_full=1 for 5 cycles mid-frame, with edge FIFO empty on alternate cycles -> no rd_en and no wr_en during stalls; output sequence identical to the unstalled run; one idle cycle after frame_done (S_FLUSH).
- Drive reset low after pixel 7 of a frame, then release -> outputs 0 asynchronously; next written pixel is treated as (0,0); frame_done after 12 further pixels.

Source files
------------

// File: rtl/canny_pkg.sv
// canny_pkg: shared pixel types, overlay state enum and default highlight colour for the Canny pipeline stages
package canny_pkg;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  typedef logic [7:0] gray_t;
  typedef enum logic {S_RUN, S_FLUSH} overlay_state_t;
  localparam logic [23:0] DEFAULT_HIGHLIGHT = 24'hFF0000;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: raster x/y position (clock, active-low async reset, advance in; x, y, last_pixel out), wraps after (WIDTH-1,HEIGHT-1)
module raster_counter #(
  parameter int WIDTH = 720,
  parameter int HEIGHT = 540,
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1,
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last_pixel
);
  logic end_x, end_y;
  assign end_x = x == XW'(WIDTH - 1);
  assign end_y = y == YW'(HEIGHT - 1);
  assign last_pixel = end_x && end_y;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      x <= end_x ? '0 : x + 1'b1;
      y <= end_x ? (end_y ? '0 : y + 1'b1) : y;
    end
endmodule

// File: rtl/canny_edge_overlay.sv
// canny_edge_overlay: paints thresholded edge pixels over the (optionally dimmed) RGB image; pops rgb/edge FIFOs together, writes out FIFO one cycle later, frame_done on last pixel
module canny_edge_overlay
  import canny_pkg::*;
#(
  parameter int          WIDTH           = 720,
  parameter int          HEIGHT          = 540,
  parameter gray_t       EDGE_THRESH     = 8'd128,
  parameter logic [23:0] HIGHLIGHT_COLOR = DEFAULT_HIGHLIGHT,
  parameter int          BORDER          = 2,
  parameter bit          DIM_BG          = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        rgb_rd_en,
  input  logic        rgb_empty,
  input  logic [23:0] rgb_dout,
  output logic        edge_rd_en,
  input  logic        edge_empty,
  input  logic [7:0]  edge_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [23:0] out_din,
  output logic        frame_done
);
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam int XHI = WIDTH - BORDER;
  localparam int YHI = HEIGHT - BORDER;
  localparam logic [XW:0] X_LO = BORDER[XW:0];
  localparam logic [XW:0] X_HI = XHI[XW:0];
  localparam logic [YW:0] Y_LO = BORDER[YW:0];
  localparam logic [YW:0] Y_HI = YHI[YW:0];
  overlay_state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic last_pixel, fire, is_edge;
  rgb_t rgb_in, dim;
  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) pos (
    .clock(clock), .reset(reset), .advance(fire), .x(x), .y(y), .last_pixel(last_pixel)
  );
  assign fire = reset && state == S_RUN && !rgb_empty && !edge_empty && !out_full;
  assign rgb_rd_en = fire;
  assign edge_rd_en = fire;
  assign rgb_in = rgb_dout;
  assign dim = '{rgb_in.r >> 1, rgb_in.g >> 1, rgb_in.b >> 1};
  assign is_edge = edge_dout >= EDGE_THRESH && {1'b0, x} >= X_LO && {1'b0, x} < X_HI &&
                   {1'b0, y} >= Y_LO && {1'b0, y} < Y_HI;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= S_RUN;
      out_wr_en <= 1'b0;
      out_din <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= fire && last_pixel ? S_FLUSH : S_RUN;
      out_wr_en <= fire;
      frame_done <= fire && last_pixel;
      if (fire) out_din <= is_edge ? HIGHLIGHT_COLOR : (DIM_BG ? dim : rgb_in);
    end
endmodule

// File: tb/tb_canny_edge_overlay.sv
// tb_canny_edge_overlay: two configurations driven from emulated FIFOs with random stalls/resets, checked every cycle against a pixel-index model
`timescale 1ns/1ps
module tb_canny_edge_overlay;
  localparam int CW[2] = '{4, 6};
  localparam int CH[2] = '{3, 6};
  localparam int CB[2] = '{0, 2};
  localparam int CD[2] = '{0, 1};
  logic clock = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  function automatic logic [23:0] model(int w, int h, int b, int dim, int idx, logic [23:0] rgb, logic [7:0] e);
    int x = idx % w;
    int y = (idx / w) % h;
    if (e >= 128 && x >= b && x < w - b && y >= b && y < h - b) return 24'hFF0000;
    if (dim != 0) return {8'(rgb[23:16] / 2), 8'(rgb[15:8] / 2), 8'(rgb[7:0] / 2)};
    return rgb;
  endfunction
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask
  initial begin
    check("pin_pass", model(4, 3, 0, 0, 5, 24'h102030, 8'h00), 24'h102030);
    check("pin_edge5", model(4, 3, 0, 0, 5, 24'h102030, 8'hFF), 24'hFF0000);
    check("pin_thr127", model(4, 3, 0, 0, 0, 24'h102030, 8'd127), 24'h102030);
    check("pin_corner_b0", model(4, 3, 0, 0, 11, 24'h102030, 8'd128), 24'hFF0000);
    check("pin_dim", model(6, 6, 2, 1, 0, 24'hFF8101, 8'h00), 24'h7F4000);
    check("pin_b22", model(6, 6, 2, 1, 14, 24'h204060, 8'hFF), 24'hFF0000);
    check("pin_b33", model(6, 6, 2, 1, 21, 24'h204060, 8'hFF), 24'hFF0000);
    check("pin_b12", model(6, 6, 2, 1, 13, 24'h204060, 8'hFF), 24'h102030);
    check("pin_b42", model(6, 6, 2, 1, 16, 24'h204060, 8'hFF), 24'h102030);
  end
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int W = CW[g];
    localparam int H = CH[g];
    localparam int B = CB[g];
    localparam int D = CD[g];
    localparam int N = W * H;
    logic reset = 1'b1;
    logic rgb_empty = 1'b1;
    logic edge_empty = 1'b1;
    logic out_full = 1'b0;
    logic [23:0] rgb_dout = '0;
    logic [7:0] edge_dout = '0;
    logic rgb_rd_en, edge_rd_en, out_wr_en, frame_done;
    logic [23:0] out_din;
    bit fin = 1'b0;
    canny_edge_overlay #(
      .WIDTH(W), .HEIGHT(H), .EDGE_THRESH(8'd128), .HIGHLIGHT_COLOR(24'hFF0000),
      .BORDER(B), .DIM_BG(D != 0)
    ) dut (
      .clock(clock), .reset(reset),
      .rgb_rd_en(rgb_rd_en), .rgb_empty(rgb_empty), .rgb_dout(rgb_dout),
      .edge_rd_en(edge_rd_en), .edge_empty(edge_empty), .edge_dout(edge_dout),
      .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din), .frame_done(frame_done)
    );
    initial begin
      logic [23:0] rq[$];
      logic [7:0] eq[$];
      logic [23:0] exp_val, rv;
      logic [7:0] ev;
      bit exp_wr, exp_fd, exp_rd, rgate, egate;
      int p, pc, rst_left, resets;
      exp_val = '0;
      exp_wr = 0;
      exp_fd = 0;
      p = 0;
      pc = 0;
      rst_left = 0;
      resets = 0;
      #1 reset = 1'b0;
      repeat (2) @(negedge clock);
      check("reset_wr", out_wr_en, 0);
      check("reset_din", out_din, 0);
      check("reset_fd", frame_done, 0);
      check("reset_rd", rgb_rd_en, 0);
      for (int cyc = 0; cyc < 1500; cyc++) begin
        @(negedge clock);
        check("wr", out_wr_en, exp_wr);
        check("din", out_din, exp_val);
        check("frame_done", frame_done, exp_fd);
        if (rst_left == 0 && resets < 4 && cyc > 200 && p % N == 7 && $urandom_range(0, 3) == 0) begin
          rst_left = 2;
          resets++;
        end
        reset = rst_left == 0;
        if (rst_left > 0) rst_left--;
        while (rq.size() < 6 && (cyc < 80 || $urandom_range(0, 3) != 0)) begin
          if (pc < 2 * N) begin
            rv = D != 0 ? 24'hFF8101 : 24'h102030;
            ev = (D != 0 || pc % N == 5) ? 8'hFF : 8'h00;
          end else begin
            rv = 24'($urandom);
            case ($urandom_range(0, 4))
              0: ev = 8'd0;
              1: ev = 8'd127;
              2: ev = 8'd128;
              3: ev = 8'd255;
              default: ev = 8'($urandom);
            endcase
          end
          rq.push_back(rv);
          eq.push_back(ev);
          pc++;
          if (cyc >= 80) break;
        end
        rgate = cyc >= 80 && $urandom_range(0, 3) == 0;
        egate = cyc >= 80 && ((cyc % 64 >= 30 && cyc % 64 < 36 && cyc % 2 == 0) || $urandom_range(0, 3) == 0);
        out_full = cyc >= 80 && ((cyc % 64 >= 30 && cyc % 64 < 35) || $urandom_range(0, 5) == 0);
        rgb_empty = rq.size() == 0 || rgate;
        edge_empty = eq.size() == 0 || egate;
        rgb_dout = rq.size() > 0 ? rq[0] : '0;
        edge_dout = eq.size() > 0 ? eq[0] : '0;
        #1;
        if (!reset) begin
          check("rst_async_wr", out_wr_en, 0);
          check("rst_async_din", out_din, 0);
          check("rst_async_fd", frame_done, 0);
          p = 0;
          exp_val = '0;
        end
        exp_rd = reset && !rgb_empty && !edge_empty && !out_full && !exp_fd;
        check("rgb_rd_en", rgb_rd_en, exp_rd);
        check("edge_rd_en", edge_rd_en, exp_rd);
        exp_wr = 0;
        exp_fd = 0;
        if (rgb_rd_en && edge_rd_en && rq.size() > 0) begin
          exp_wr = 1;
          exp_val = model(W, H, B, D, p, rq[0], eq[0]);
          exp_fd = p % N == N - 1;
          p++;
          void'(rq.pop_front());
          void'(eq.pop_front());
        end
      end
      fin = 1'b1;
    end
  end
  initial begin
    for (int i = 0; i < 4000 && !(cfg[0].fin && cfg[1].fin); i++) @(posedge clock);
    if (!(cfg[0].fin && cfg[1].fin)) begin
      total++;
      bad++;
      $display("FAIL timeout: got unfinished want finished");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
